// File: rtl/fpu_host_seq_if.sv
// FPU register bus: byte-wide address/data with active-low chip select and
// separate read/write strobes, plus the end-of-command handshake.
// Ports: addr/dout/cs_n/rd_n/wr_n/end_ack driven by the host, din/cmd_end by the FPU.
interface fpu_host_seq_if;
  logic [5:0] addr;
  logic [7:0] dout;
  logic [7:0] din;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       cmd_end;
  logic       end_ack;

  modport master (
    output addr, dout, cs_n, rd_n, wr_n, end_ack,
    input  din, cmd_end
  );

  modport slave (
    input  addr, dout, cs_n, rd_n, wr_n, end_ack,
    output din, cmd_end
  );
endinterface

// File: rtl/fpu_host_seq.sv
// Purpose: runs one FPU operation: 9 register writes, wait cmd_end, 4 reads, ack.
// Latency: 9*(S+2) write cycles, wait for cmd_end (max TIMEOUT), 4*(S+2) reads, ack, 1 fin.
// Backpressure: start accepted only while ready=1; starts while busy are dropped.
// Ports: clk, arst_n; host side start/op/opa/opb in, ready/done/result/err out;
//        bus = FPU register bus (master side).
module fpu_host_seq #(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  fpu_host_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT_END, ACK, FIN} state_t;

  localparam logic [3:0]  S_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;     // byte index == FPU register address 0x0..0xC
  logic [3:0]  scnt_q, scnt_d;   // cycles spent in STROBE
  logic [15:0] wcnt_q, wcnt_d;   // cycles spent in WAIT_END
  logic [31:0] opa_q, opb_q;
  logic [3:0]  op_q;
  logic        accept, timeout_hit;
  logic        is_read;

  assign is_read = (idx_q >= 4'd9);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    scnt_d      = scnt_q;
    wcnt_d      = wcnt_q;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = 4'd0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        scnt_d  = 4'd0;
        state_d = STROBE;
      end
      STROBE: begin
        if (scnt_q == S_LAST) state_d = HOLD;
        else                  scnt_d  = scnt_q + 4'd1;
      end
      HOLD: begin
        if (idx_q == 4'd8) begin
          wcnt_d  = 16'd0;
          state_d = WAIT_END;
        end else if (idx_q == 4'd12) begin
          state_d = ACK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = SETUP;
        end
      end
      WAIT_END: begin
        // cmd_end wins over an expiring timeout in the same cycle
        if (bus.cmd_end) begin
          idx_d   = 4'd9;
          state_d = SETUP;
        end else if (wcnt_q == T_LAST) begin
          timeout_hit = 1'b1;
          state_d     = FIN;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ACK: begin
        if (!bus.cmd_end) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus controls decode straight from the state so reset releases them at once.
  always_comb begin
    bus.cs_n    = !(state_q == SETUP || state_q == STROBE || state_q == HOLD);
    bus.wr_n    = !(state_q == STROBE && !is_read);
    bus.rd_n    = !(state_q == STROBE && is_read);
    bus.end_ack = (state_q == ACK);
    bus.addr    = {2'b00, idx_q};
    ready       = (state_q == IDLE);
    done        = (state_q == FIN);
    case (idx_q)
      4'd0:    bus.dout = opa_q[7:0];
      4'd1:    bus.dout = opa_q[15:8];
      4'd2:    bus.dout = opa_q[23:16];
      4'd3:    bus.dout = opa_q[31:24];
      4'd4:    bus.dout = opb_q[7:0];
      4'd5:    bus.dout = opb_q[15:8];
      4'd6:    bus.dout = opb_q[23:16];
      4'd7:    bus.dout = opb_q[31:24];
      4'd8:    bus.dout = {4'b0000, op_q};
      default: bus.dout = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      scnt_q  <= 4'd0;
      wcnt_q  <= 16'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      op_q    <= 4'd0;
      err     <= 1'b0;
      result  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        opa_q <= opa;
        opb_q <= opb;
        op_q  <= op;
        err   <= 1'b0;
      end else if (timeout_hit) begin
        err <= 1'b1;
      end
      // read data is taken on the final strobe cycle
      if (state_q == STROBE && scnt_q == S_LAST && is_read) begin
        case (idx_q)
          4'd9:    result[7:0]   <= bus.din;
          4'd10:   result[15:8]  <= bus.din;
          4'd11:   result[23:16] <= bus.din;
          4'd12:   result[31:24] <= bus.din;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_host_seq.sv
module tb_fpu_host_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, start, sel;
  logic [3:0]  op;
  logic [31:0] opa, opb;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  fpu_host_seq_if bus_a();
  fpu_host_seq_if bus_b();
  logic        rdy_a, done_a, err_a, rdy_b, done_b, err_b;
  logic [31:0] res_a, res_b;

  // FPU model state
  logic        m_cmd_end;
  logic [7:0]  m_din;
  logic [31:0] mdl_res;
  int          mdl_delay, mdl_hold, dcnt, hcnt;
  logic        mdl_never, pend;

  assign bus_a.din     = m_din;
  assign bus_b.din     = m_din;
  assign bus_a.cmd_end = m_cmd_end & ~sel;
  assign bus_b.cmd_end = m_cmd_end & sel;

  fpu_host_seq #(.STROBE_CYCLES(1), .TIMEOUT(16)) dut_a (
    .clk(clk), .arst_n(arst_n), .start(start & ~sel), .op(op), .opa(opa), .opb(opb),
    .ready(rdy_a), .done(done_a), .result(res_a), .err(err_a), .bus(bus_a));
  fpu_host_seq #(.STROBE_CYCLES(3), .TIMEOUT(1024)) dut_b (
    .clk(clk), .arst_n(arst_n), .start(start & sel), .op(op), .opa(opa), .opb(opb),
    .ready(rdy_b), .done(done_b), .result(res_b), .err(err_b), .bus(bus_b));

  // selected DUT view
  logic        cs_n, rd_n, wr_n, end_ack, ready, done, err;
  logic [5:0]  addr;
  logic [7:0]  dout;
  logic [31:0] result;
  assign cs_n    = sel ? bus_b.cs_n    : bus_a.cs_n;
  assign rd_n    = sel ? bus_b.rd_n    : bus_a.rd_n;
  assign wr_n    = sel ? bus_b.wr_n    : bus_a.wr_n;
  assign end_ack = sel ? bus_b.end_ack : bus_a.end_ack;
  assign addr    = sel ? bus_b.addr    : bus_a.addr;
  assign dout    = sel ? bus_b.dout    : bus_a.dout;
  assign ready   = sel ? rdy_b  : rdy_a;
  assign done    = sel ? done_b : done_a;
  assign err     = sel ? err_b  : err_a;
  assign result  = sel ? res_b  : res_a;

  always_comb begin
    m_din = 8'hEE;
    case (addr)
      6'h9: m_din = mdl_res[7:0];
      6'hA: m_din = mdl_res[15:8];
      6'hB: m_din = mdl_res[23:16];
      6'hC: m_din = mdl_res[31:24];
      default: m_din = 8'hEE;
    endcase
  end

  // cmd_end rises mdl_delay cycles after the op write; after end_ack rises it
  // stays high for mdl_hold more sampled cycles.
  initial begin
    m_cmd_end = 1'b0; pend = 1'b0; dcnt = 0; hcnt = 0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        m_cmd_end = 1'b0; pend = 1'b0;
      end else begin
        if (!cs_n && !wr_n && addr == 6'h8) begin
          dcnt = mdl_delay; pend = !mdl_never;
        end else if (pend) begin
          if (dcnt <= 1) begin m_cmd_end = 1'b1; hcnt = mdl_hold; pend = 1'b0; end
          else dcnt = dcnt - 1;
        end
        if (m_cmd_end && end_ack) begin
          if (hcnt == 0) m_cmd_end = 1'b0;
          else hcnt = hcnt - 1;
        end
      end
    end
  end

  // bus monitor
  int          nw, nr, viol, badlen, unstable, ndone, we_cyc, done_cyc, ack_rise, ack_fall, run, exp_s;
  logic [5:0]  wr_addr [16];
  logic [7:0]  wr_dat  [16];
  int          wr_cyc  [16];
  logic [5:0]  rd_addr [8];
  int          rd_cyc  [8];
  logic        done_err_s, p_cs_n, p_ack;
  logic [31:0] done_res_s;
  logic [5:0]  p_addr, s_addr;
  logic [7:0]  s_dout;

  task automatic clear_mon();
    nw = 0; nr = 0; viol = 0; badlen = 0; unstable = 0; ndone = 0; run = 0;
    we_cyc = -1; done_cyc = -1; ack_rise = -1; ack_fall = -1;
    exp_s = sel ? 3 : 1;
  endtask

  initial begin
    p_cs_n = 1'b1; p_ack = 1'b0; p_addr = 6'd0; s_addr = 6'd0; s_dout = 8'd0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        run = 0;
      end else begin
        if (!rd_n && !wr_n) viol++;
        if ((!rd_n || !wr_n) && cs_n) viol++;
        if (!rd_n || !wr_n) begin
          if (run == 0) begin
            s_addr = addr; s_dout = dout;
            if (!wr_n) begin
              if (nw < 16) begin wr_addr[nw] = addr; wr_dat[nw] = dout; wr_cyc[nw] = cyc; end
              nw++;
            end else begin
              if (nr < 8) begin rd_addr[nr] = addr; rd_cyc[nr] = cyc; end
              nr++;
            end
          end else if (addr !== s_addr || dout !== s_dout) unstable++;
          run++;
        end else if (run != 0) begin
          if (run != exp_s) badlen++;
          if (addr !== s_addr || dout !== s_dout || cs_n) unstable++;
          run = 0;
        end
        if (cs_n && !p_cs_n && p_addr == 6'h8) we_cyc = cyc;
        if (done) begin ndone++; done_cyc = cyc; done_err_s = err; done_res_s = result; end
        if (end_ack && !p_ack) ack_rise = cyc;
        if (!end_ack && p_ack) ack_fall = cyc;
      end
      p_cs_n = cs_n; p_ack = end_ack; p_addr = addr;
    end
  end

  task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o,
                         output int acc);
    @(negedge clk); #1;
    opa = a; opb = b; op = o; start = 1'b1;
    acc = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 4000 && ndone == 0; k++) begin @(negedge clk); #1; end
    checks++;
    if (ndone == 0) begin errors++; $display("FAIL %s_timeout: done count %0d, required >0", name, ndone); end
  endtask

  task automatic check_bus(input string name);
    checks++;
    if (viol !== 0 || badlen !== 0 || unstable !== 0) begin
      errors++;
      $display("FAIL %s_bus: viol=%0d badlen=%0d unstable=%0d, required all 0", name, viol, badlen, unstable);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset_host: ready=%b done=%b err=%b result=%h, required 1 0 0 0", ready, done, err, result);
    end
    checks++;
    if (cs_n !== 1'b1 || rd_n !== 1'b1 || wr_n !== 1'b1 || end_ack !== 1'b0 || addr !== 6'd0 || dout !== 8'd0) begin
      errors++; $display("FAIL reset_bus: cs_n=%b rd_n=%b wr_n=%b ack=%b addr=%h dout=%h", cs_n, rd_n, wr_n, end_ack, addr, dout);
    end
    @(negedge clk); arst_n = 1'b1;
  endtask

  task automatic test_basic();
    int acc;
    logic [31:0] a, b;
    logic [7:0] eb [9];
    a = 32'h3F800000; b = 32'h40000000;
    for (int i = 0; i < 4; i++) begin eb[i] = a[8*i +: 8]; eb[i+4] = b[8*i +: 8]; end
    eb[8] = 8'h00;
    mdl_res = 32'h40400000; mdl_delay = 5; mdl_hold = 0; mdl_never = 1'b0;
    clear_mon();
    run_seq(a, b, 4'd0, acc);
    wait_done("basic");
    checks++;
    if (nw !== 9) begin errors++; $display("FAIL basic_nwrites: %0d, required 9", nw); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (wr_addr[i] !== 6'(i) || wr_dat[i] !== eb[i] || wr_cyc[i] - acc !== 1 + 3*i) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h dat=%h cyc=%0d, required %h %h %0d",
                 i, wr_addr[i], wr_dat[i], wr_cyc[i] - acc, i, eb[i], 1 + 3*i);
      end
    end
    checks++;
    if (we_cyc - acc !== 27) begin errors++; $display("FAIL basic_write_phase: %0d, required 27", we_cyc - acc); end
    checks++;
    if (nr !== 4 || rd_addr[0] !== 6'h9 || rd_addr[1] !== 6'hA || rd_addr[2] !== 6'hB || rd_addr[3] !== 6'hC) begin
      errors++; $display("FAIL basic_reads: n=%0d first=%h last=%h, required 4 9 C", nr, rd_addr[0], rd_addr[3]);
    end
    checks++;
    if (rd_cyc[3] - rd_cyc[0] !== 9) begin errors++; $display("FAIL basic_read_spacing: %0d, required 9", rd_cyc[3] - rd_cyc[0]); end
    checks++;
    if (done_res_s !== 32'h40400000 || done_err_s !== 1'b0) begin
      errors++; $display("FAIL basic_result: %h err=%b, required 40400000 0", done_res_s, done_err_s);
    end
    @(negedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_ready_after: ready=%b done=%b, required 1 0", ready, done); end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (ndone !== 1) begin errors++; $display("FAIL basic_done_once: %0d, required 1", ndone); end
    check_bus("basic");
  endtask

  task automatic test_ack_hold();
    int acc;
    mdl_res = 32'h41200000; mdl_delay = 5; mdl_hold = 4; mdl_never = 1'b0;
    clear_mon();
    run_seq(32'h40A00000, 32'h40000000, 4'd2, acc);
    wait_done("ack");
    // ack high on its rising cycle plus the 4 cycles cmd_end is still seen high
    checks++;
    if (ack_fall - ack_rise !== 5 || done_cyc !== ack_fall) begin
      errors++; $display("FAIL ack_hold: high=%0d done_at=%0d fall_at=%0d, required 5 and equal", ack_fall - ack_rise, done_cyc, ack_fall);
    end
    checks++;
    if (done_res_s !== 32'h41200000) begin errors++; $display("FAIL ack_result: %h, required 41200000", done_res_s); end
    mdl_hold = 0;
  endtask

  task automatic test_timeout();
    int acc;
    mdl_res = 32'hDEADBEEF; mdl_never = 1'b1;
    clear_mon();
    run_seq(32'h3F800000, 32'h3F800000, 4'd0, acc);
    wait_done("timeout");
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL timeout_no_reads: %0d, required 0", nr); end
    checks++;
    if (done_cyc - we_cyc !== 16) begin errors++; $display("FAIL timeout_delay: %0d, required 16", done_cyc - we_cyc); end
    checks++;
    if (done_err_s !== 1'b1 || done_res_s !== 32'h41200000) begin
      errors++; $display("FAIL timeout_err_result: err=%b res=%h, required 1 41200000", done_err_s, done_res_s);
    end
    mdl_never = 1'b0;
  endtask

  task automatic test_ignored_start();
    int acc;
    mdl_res = 32'hC0000000; mdl_delay = 5;
    clear_mon();
    run_seq(32'h3F800000, 32'h40400000, 4'd1, acc);
    repeat (4) @(negedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ignored_busy_ready: %b, required 0", ready); end
    start = 1'b1; @(negedge clk); #1; start = 1'b0;
    wait_done("ignored");
    repeat (10) @(negedge clk); #1;
    checks++;
    if (nw !== 9 || ndone !== 1 || wr_dat[8] !== 8'h01) begin
      errors++; $display("FAIL ignored_start: writes=%0d done=%0d op=%h, required 9 1 01", nw, ndone, wr_dat[8]);
    end
    checks++;
    if (done_res_s !== 32'hC0000000 || done_err_s !== 1'b0) begin
      errors++; $display("FAIL ignored_result: %h err=%b, required C0000000 0", done_res_s, done_err_s);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    mdl_res = 32'h40400000;
    clear_mon();
    run_seq(32'h40C00000, 32'h40000000, 4'd3, acc);
    wait_done("b2b");
    checks++;
    if (nw !== 9 || nr !== 4 || wr_dat[8] !== 8'h03 || done_res_s !== 32'h40400000 || done_err_s !== 1'b0) begin
      errors++; $display("FAIL b2b: w=%0d r=%0d op=%h res=%h err=%b", nw, nr, wr_dat[8], done_res_s, done_err_s);
    end
    check_bus("b2b");
  endtask

  task automatic test_fast_end();
    int acc;
    mdl_res = 32'h12345678; mdl_delay = 1;
    clear_mon();
    run_seq(32'h11111111, 32'h22222222, 4'd0, acc);
    wait_done("fast");
    checks++;
    if (rd_cyc[0] - we_cyc !== 2) begin errors++; $display("FAIL fast_end_wait: %0d, required 2", rd_cyc[0] - we_cyc); end
    checks++;
    if (done_res_s !== 32'h12345678) begin errors++; $display("FAIL fast_end_result: %h, required 12345678", done_res_s); end
    mdl_delay = 5;
  endtask

  task automatic test_strobe3();
    int acc;
    sel = 1'b1;
    mdl_res = 32'h3F800000; mdl_delay = 5;
    clear_mon();
    run_seq(32'h40000000, 32'h40000000, 4'd3, acc);
    wait_done("s3");
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (wr_cyc[i] - acc !== 1 + 5*i) begin
        errors++; $display("FAIL s3_write%0d_cycle: %0d, required %0d", i, wr_cyc[i] - acc, 1 + 5*i);
      end
    end
    checks++;
    if (we_cyc - acc !== 45) begin errors++; $display("FAIL s3_write_phase: %0d, required 45", we_cyc - acc); end
    checks++;
    if (nr !== 4 || rd_cyc[3] - rd_cyc[0] !== 15) begin errors++; $display("FAIL s3_reads: n=%0d span=%0d, required 4 15", nr, rd_cyc[3] - rd_cyc[0]); end
    checks++;
    if (done_res_s !== 32'h3F800000) begin errors++; $display("FAIL s3_result: %h, required 3F800000", done_res_s); end
    check_bus("s3");
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int acc;
    bit hit;
    hit = 1'b0;
    mdl_res = 32'h40400000; mdl_delay = 5;
    clear_mon();
    run_seq(32'h3F800000, 32'h40000000, 4'd0, acc);
    for (int k = 0; k < 100 && !hit; k++) begin
      if (!wr_n && addr == 6'h5) hit = 1'b1;
      else begin @(negedge clk); #1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach: strobe of addr 5 not seen"); end
    arst_n = 1'b0; #1;
    checks++;
    if (wr_n !== 1'b1 || rd_n !== 1'b1 || cs_n !== 1'b1 || ready !== 1'b1 || addr !== 6'd0 || result !== 32'd0) begin
      errors++; $display("FAIL rstmid_release: wr_n=%b rd_n=%b cs_n=%b ready=%b addr=%h res=%h", wr_n, rd_n, cs_n, ready, addr, result);
    end
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    clear_mon();
    repeat (6) @(negedge clk); #1;
    checks++;
    if (nw !== 0 || cs_n !== 1'b1 || ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_no_resume: writes=%0d cs_n=%b ready=%b, required 0 1 1", nw, cs_n, ready);
    end
    run_seq(32'h3F800000, 32'h40000000, 4'd0, acc);
    wait_done("rstmid");
    checks++;
    if (nw !== 9 || wr_addr[0] !== 6'h0 || wr_addr[5] !== 6'h5 || done_res_s !== 32'h40400000) begin
      errors++; $display("FAIL rstmid_rerun: writes=%0d first=%h res=%h, required 9 00 40400000", nw, wr_addr[0], done_res_s);
    end
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; sel = 1'b0; op = 4'd0; opa = 32'd0; opb = 32'd0;
    mdl_res = 32'd0; mdl_delay = 5; mdl_hold = 0; mdl_never = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_ack_hold();
    test_timeout();
    test_ignored_start();
    test_back_to_back();
    test_fast_end();
    test_strobe3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_host_seq.md
FPU_HOST_SEQ -- requirements
Module: fpu_host_seq

Interface
REQ-001 STROBE_CYCLES, 1, width in clk cycles of each rd_n/wr_n low pulse (legal 1..15).
REQ-002 TIMEOUT, 1024, max clk cycles to wait for cmd_end before aborting (legal 2..65535).
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 arst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to run one FPU operation; ignored unless ready=1.
REQ-006 op  in  4  operation code written to FPU register 0x8 (0=add, 1=sub, 2=mul, 3=div).
REQ-007 opa, opb  in  32 each  IEEE-754 single operands, captured on accepted start.
REQ-008 ready  out  1  high when idle and able to accept start.
REQ-009 done  out  1  one-cycle pulse when the sequence ends; result/err valid from that cycle until the next accepted start.
REQ-010 result  out  32  result read back from FPU registers 0x9..0xC (byte 0x9 = bits 7:0).
REQ-011 err  out  1  set with done when the cmd_end timeout expired.
REQ-012 addr  out  6  FPU register address.
REQ-013 dout  out  8  write data to FPU databus_in.
REQ-014 din  in  8  read data from FPU databus_out.
REQ-015 cs_n, rd_n, wr_n  out  1 each  active-low FPU chip select, read and write strobes.
REQ-016 cmd_end  in  1  FPU end-of-command.
REQ-017 end_ack  out  1  acknowledge of cmd_end.

Function
REQ-018 States: IDLE, SETUP, STROBE, HOLD, WAIT_END, ACK, FIN; a 4-bit byte index selects the current access.
REQ-019 Accepted start (IDLE, start=1) SHALL capture opa, opb, op, clear err, drive ready=0 and go to SETUP with index 0.
REQ-020 Access order: writes addr 0x0-0x3 = opa bytes LSB first, 0x4-0x7 = opb, 0x8 = {4'b0, op}; then WAIT_END; then reads 0x9-0xC.
REQ-021 Each access: SETUP 1 cycle (cs_n=0, addr/dout valid, strobes high); STROBE exactly STROBE_CYCLES cycles (rd_n or wr_n =0); HOLD 1 cycle (strobes high, cs_n=0, addr/dout unchanged).
REQ-022 addr and dout SHALL be stable from SETUP through HOLD; rd_n and wr_n SHALL never be low together; strobes only low while cs_n=0.
REQ-023 Read data SHALL be sampled from din on the last STROBE cycle into the addressed result byte.
REQ-024 After HOLD of access 0x8, cs_n=1 and state WAIT_END; a 16-bit counter SHALL count cycles from 0.
REQ-025 WAIT_END: cmd_end=1 -> SETUP of read 0x9; counter reaching TIMEOUT-1 with cmd_end=0 -> err=1, FIN (no reads, result unchanged).
REQ-026 After HOLD of read 0xC -> ACK: end_ack=1 held until cmd_end sampled 0, then end_ack=0 and FIN.
REQ-027 FIN: done=1 for one cycle, next state IDLE; ready=1 from the IDLE cycle after.
REQ-028 cs_n=1, rd_n=1, wr_n=1, end_ack=0 in IDLE, WAIT_END, ACK, FIN.
REQ-029 start while ready=0 SHALL be ignored and not queued.
REQ-030 With STROBE_CYCLES=S, cycles from accepted start to first WAIT_END cycle = 9*(S+2); read phase = 4*(S+2).
REQ-031 cmd_end already high on entering WAIT_END SHALL proceed to reads on the next cycle (no extra wait).

Reset
REQ-032 arst_n=0 SHALL immediately force IDLE, cs_n=rd_n=wr_n=1, end_ack=0, done=0, err=0, result=0, ready=1, addr=0, dout=0, counters 0.
REQ-033 Reset mid-access SHALL release strobes asynchronously; no partial sequence resumes after reset release.

Verification
REQ-034 S=1, opa=0x3F800000, opb=0x40000000, op=0, FPU model returns 0x40400000 with cmd_end 5 cycles after op write -> 9 writes in 27 cycles with correct addr/data, reads 0x00,0x00,0x40,0x40, result=0x40400000, err=0, done pulse once.
REQ-035 S=3 -> every rd_n/wr_n pulse exactly 3 cycles low, SETUP/HOLD 1 cycle each, write phase 45 cycles.
REQ-036 TIMEOUT=16, cmd_end never asserted -> no reads, done with err=1 exactly 16 cycles after entering WAIT_END, result keeps previous value.
REQ-037 cmd_end held high 4 cycles after end_ack rises -> end_ack stays high until cmd_end low, then done.
REQ-038 start pulsed during write phase -> ignored; second sequence only after ready=1 runs normally.
REQ-039 arst_n low during STROBE of addr 0x5 -> strobes/cs_n high same cycle, ready=1, next start runs full sequence from addr 0x0.
